// File: rtl/flash_spi_controller.sv
// flash_spi_controller: CPU word requests -> SPI mode-0 NOR flash (READ, or WREN + PAGE PROGRAM + WIP poll); read ack 1+64*2*CLK_DIV cycles after accept.
// Request is level-held until the one-cycle ack, and none is accepted while busy. Define FLASH_FAST_READ_EN for 0x0B reads with 8 dummy clocks.
module flash_spi_controller #(
  parameter int CLK_DIV        = 2,
  parameter int CS_HIGH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flash_request,
  output logic        flash_ack,
  input  logic        flash_write,
  input  logic [31:0] flash_address,
  output logic [31:0] flash_rdata,
  input  logic [31:0] flash_wdata,
  output logic        spi_clk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  typedef enum logic [3:0] {IDLE, WREN, GAP, CMD, ADDR, DUMMY, DATA, POLL, DONE} state_t;

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] RD_OP = 8'h0B;
  localparam logic       FAST  = 1'b1;
`else
  localparam logic [7:0] RD_OP = 8'h03;
  localparam logic       FAST  = 1'b0;
`endif

  localparam int PHW = $clog2(2 * CLK_DIV);
  localparam int GW  = $clog2(CS_HIGH_CYCLES + 1);
  localparam logic [PHW-1:0] PH_MID   = PHW'(CLK_DIV - 1);
  localparam logic [PHW-1:0] PH_LAST  = PHW'(2 * CLK_DIV - 1);
  localparam logic [GW-1:0]  GAP_LOAD = GW'(CS_HIGH_CYCLES);

  state_t          state, state_nxt;
  logic [PHW-1:0]  ph;
  logic [5:0]      bit_cnt;
  logic [31:0]     shreg;
  logic [GW-1:0]   gap;
  logic            cs_q, sck_q;
  logic            wr_q, gap_to_poll, poll_cmd;
  logic [21:0]     addr_q;
  logic [31:0]     wdata_q, rdata_q;
  logic            sync1, sync2;
  logic            shifting, bit_end, last_bit, accept;
  logic            unused_addr;

  assign unused_addr = ^{flash_address[31:24], flash_address[1:0]};
  assign shifting = (state == WREN) || (state == CMD) || (state == ADDR) ||
                    (state == DUMMY) || (state == DATA) || (state == POLL);
  assign bit_end  = shifting && (ph == PH_LAST);
  assign last_bit = bit_end && (bit_cnt == 6'd0);
  assign accept   = (state == IDLE) && flash_request && (gap == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept)   state_nxt = flash_write ? WREN : CMD;
      WREN:  if (last_bit) state_nxt = GAP;
      GAP:   if (gap == '0) state_nxt = gap_to_poll ? POLL : CMD;
      CMD:   if (last_bit) state_nxt = ADDR;
      ADDR:  if (last_bit) state_nxt = (FAST && !wr_q) ? DUMMY : DATA;
      DUMMY: if (last_bit) state_nxt = DATA;
      DATA:  if (last_bit) state_nxt = wr_q ? GAP : DONE;
      // sync2 holds WIP (bit0) on the last bit of a status byte
      POLL:  if (last_bit && !poll_cmd && !sync2) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph <= '0; bit_cnt <= '0; shreg <= '0; gap <= GAP_LOAD;
      cs_q <= 1'b1; sck_q <= 1'b0; wr_q <= 1'b0; gap_to_poll <= 1'b0; poll_cmd <= 1'b0;
      addr_q <= '0; wdata_q <= '0; rdata_q <= '0; sync1 <= 1'b0; sync2 <= 1'b0;
    end else begin
      sync1 <= spi_miso;
      sync2 <= sync1;
      if (gap != '0) gap <= gap - 1'b1;
      if (shifting) begin
        ph <= bit_end ? '0 : ph + 1'b1;
        if (ph == PH_MID) sck_q <= 1'b1;
        if (bit_end) begin
          sck_q   <= 1'b0;
          shreg   <= {shreg[30:0], sync2};
          bit_cnt <= bit_cnt - 1'b1;
        end
      end
      case (state)
        IDLE: if (accept) begin
          wr_q <= flash_write; addr_q <= flash_address[23:2]; wdata_q <= flash_wdata;
          cs_q <= 1'b0; ph <= '0; bit_cnt <= 6'd7; gap_to_poll <= 1'b0;
          shreg <= {(flash_write ? 8'h06 : RD_OP), 24'h0};
        end
        WREN: if (last_bit) begin
          cs_q <= 1'b1; gap <= GAP_LOAD; shreg <= '0;
        end
        GAP: if (gap == '0) begin
          cs_q <= 1'b0; ph <= '0; bit_cnt <= 6'd7; poll_cmd <= 1'b1;
          shreg <= {(gap_to_poll ? 8'h05 : 8'h02), 24'h0};
        end
        CMD: if (last_bit) begin
          shreg <= {addr_q, 2'b00, 8'h00}; bit_cnt <= 6'd23;
        end
        ADDR: if (last_bit) begin
          shreg   <= wr_q ? wdata_q : 32'h0;
          bit_cnt <= (FAST && !wr_q) ? 6'd7 : 6'd31;
        end
        DUMMY: if (last_bit) begin
          shreg <= '0; bit_cnt <= 6'd31;
        end
        DATA: if (last_bit) begin
          cs_q <= 1'b1; gap <= GAP_LOAD; shreg <= '0; gap_to_poll <= wr_q;
          if (!wr_q) rdata_q <= {shreg[30:0], sync2};
        end
        POLL: if (last_bit) begin
          shreg <= '0; bit_cnt <= 6'd7; poll_cmd <= 1'b0;
          if (!poll_cmd && !sync2) begin
            cs_q <= 1'b1; gap <= GAP_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    flash_ack   = (state == DONE);
    flash_rdata = rdata_q;
    spi_cs_n    = cs_q;
    spi_clk     = sck_q;
    spi_mosi    = shreg[31];
  end
endmodule

// File: tb/tb_flash_spi_controller.sv
// Directed bench for flash_spi_controller with a behavioural SPI NOR flash model.
// Honours FLASH_FAST_READ_EN for the expected read opcode and latency.
module tb_flash_spi_controller;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flash_request = 1'b0;
  logic        flash_write = 1'b0;
  logic [31:0] flash_address = '0;
  logic [31:0] flash_wdata = '0;
  logic        flash_ack;
  logic [31:0] flash_rdata;
  logic        spi_clk, spi_cs_n, spi_mosi;
  logic        spi_miso = 1'b0;

  int total = 0;
  int bad = 0;

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] RD_OP = 8'h0B;
  localparam int RD_LAT = 289;
  localparam int RD_BYTES = 9;
`else
  localparam logic [7:0] RD_OP = 8'h03;
  localparam int RD_LAT = 257;
  localparam int RD_BYTES = 8;
`endif

  always #5 clk = ~clk;

  flash_spi_controller #(.CLK_DIV(2), .CS_HIGH_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .flash_request(flash_request), .flash_ack(flash_ack), .flash_write(flash_write),
    .flash_address(flash_address), .flash_rdata(flash_rdata), .flash_wdata(flash_wdata),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  // flash model state
  int         nrise = 0;
  logic [7:0] acc = '0;
  logic [7:0] cmd = '0;
  logic [23:0] maddr = '0;
  int         wip_bytes = 0;
  logic [7:0] mosi_q[$];
  // monitors
  int   ack_cnt = 0;
  int   hi_run = 0;
  int   min_gap = 1000;
  logic seen_low = 1'b0;

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    case (a)
      24'h123454: return 32'hDEADBEEF;
      24'h000040: return 32'hA5A50F0F;
      default:    return 32'h01234567;
    endcase
  endfunction

  function automatic logic miso_bit(input int n);
    logic [31:0] w;
    logic [7:0]  st;
    w = mem_word(maddr);
    if (cmd == 8'h03 && n >= 32 && n < 64) return w[63-n];
    if (cmd == 8'h0B && n >= 40 && n < 72) return w[71-n];
    if (cmd == 8'h05 && n >= 8) begin
      st = (((n - 8) / 8) < wip_bytes) ? 8'h01 : 8'h00;
      return st[7-((n-8)%8)];
    end
    return 1'b0;
  endfunction

  always @(negedge spi_cs_n) nrise = 0;

  always @(posedge spi_clk) if (!spi_cs_n) begin
    acc = {acc[6:0], spi_mosi};
    if (nrise >= 8 && nrise < 32) maddr = {maddr[22:0], spi_mosi};
    nrise++;
    if (nrise % 8 == 0) begin
      mosi_q.push_back(acc);
      if (nrise == 8) cmd = acc;
    end
  end

  always @(negedge spi_clk) if (!spi_cs_n) spi_miso = miso_bit(nrise);

  always @(negedge clk) begin
    if (flash_ack) ack_cnt++;
    if (spi_cs_n) hi_run++;
    else begin
      if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
      seen_low = 1'b1;
      hi_run = 0;
    end
  end

  task automatic test_reset;
    int act;
    reset_n = 1'b0; flash_request = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (spi_cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b exp=1", spi_cs_n); end
    total++; if (spi_clk !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b exp=0", spi_clk); end
    total++; if (flash_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", flash_ack); end
    total++; if (flash_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", flash_rdata); end
    total++; if (spi_mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b exp=0", spi_mosi); end
    reset_n = 1'b1; act = 0; ack_cnt = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (spi_cs_n !== 1'b1 || spi_clk !== 1'b0) act++;
    end
    total++; if (act !== 0) begin bad++; $display("FAIL idle_cs_activity got=%0d exp=0", act); end
    total++; if (ack_cnt !== 0) begin bad++; $display("FAIL idle_ack got=%0d exp=0", ack_cnt); end
  endtask

  task automatic test_read;
    int n;
    logic cs1;
    logic [7:0] exp_b [4];
    exp_b = '{RD_OP, 8'h12, 8'h34, 8'h54};
    mosi_q.delete(); ack_cnt = 0;
    flash_address = 32'h0012_3457; flash_write = 1'b0; flash_request = 1'b1;
    n = 0; cs1 = 1'b0;
    while (!flash_ack && n < 2000) begin
      @(posedge clk); #1; n++;
      if (n == 1) cs1 = !spi_cs_n;
    end
    flash_request = 1'b0;
    total++; if (cs1 !== 1'b1) begin bad++; $display("FAIL read_cs_cycle1 got=%b exp=1", cs1); end
    total++; if (n !== RD_LAT) begin bad++; $display("FAIL read_latency got=%0d exp=%0d", n, RD_LAT); end
    total++; if (flash_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL read_rdata got=%h exp=deadbeef", flash_rdata); end
    total++; if (spi_cs_n !== 1'b1) begin bad++; $display("FAIL read_cs_at_ack got=%b exp=1", spi_cs_n); end
    repeat (20) @(posedge clk);
    #1;
    total++; if (ack_cnt !== 1) begin bad++; $display("FAIL read_ack_count got=%0d exp=1", ack_cnt); end
    total++; if (mosi_q.size() !== RD_BYTES) begin bad++; $display("FAIL read_bytes got=%0d exp=%0d", mosi_q.size(), RD_BYTES); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mosi_q[i] !== exp_b[i]) begin bad++; $display("FAIL read_mosi[%0d] got=%h exp=%h", i, mosi_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_write;
    int n;
    logic [7:0] exp_w [10];
    exp_w = '{8'h06, 8'h02, 8'h00, 8'h01, 8'h00, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h05};
    mosi_q.delete(); ack_cnt = 0; wip_bytes = 3; seen_low = 1'b0; min_gap = 1000;
    flash_address = 32'h0000_0100; flash_wdata = 32'hCAFEBABE; flash_write = 1'b1; flash_request = 1'b1;
    n = 0;
    while (!flash_ack && n < 5000) begin @(posedge clk); #1; n++; end
    flash_request = 1'b0; flash_write = 1'b0;
    total++; if (flash_ack !== 1'b1) begin bad++; $display("FAIL write_ack_timeout got=%b exp=1", flash_ack); end
    total++; if (n < 457) begin bad++; $display("FAIL write_latency got=%0d exp>=457", n); end
    total++; if (flash_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL write_rdata_hold got=%h exp=deadbeef", flash_rdata); end
    repeat (20) @(posedge clk);
    #1;
    total++; if (ack_cnt !== 1) begin bad++; $display("FAIL write_ack_count got=%0d exp=1", ack_cnt); end
    total++; if (min_gap < 4 || min_gap >= 1000) begin bad++; $display("FAIL write_cs_gap got=%0d exp>=4", min_gap); end
    total++; if (mosi_q.size() !== 14) begin bad++; $display("FAIL write_bytes got=%0d exp=14", mosi_q.size()); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (mosi_q[i] !== exp_w[i]) begin bad++; $display("FAIL write_mosi[%0d] got=%h exp=%h", i, mosi_q[i], exp_w[i]); end
    end
    wip_bytes = 0;
  endtask

  task automatic test_back_to_back;
    int n;
    ack_cnt = 0; seen_low = 1'b0; min_gap = 1000;
    flash_address = 32'h0; flash_write = 1'b0; flash_request = 1'b1;
    n = 0;
    while (!flash_ack && n < 2000) begin @(posedge clk); #1; n++; end
    total++; if (flash_rdata !== 32'h01234567) begin bad++; $display("FAIL b2b_first_rdata got=%h exp=01234567", flash_rdata); end
    flash_address = 32'h0000_0040;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!flash_ack && n < 2000);
    flash_request = 1'b0;
    total++; if (flash_ack !== 1'b1) begin bad++; $display("FAIL b2b_second_ack got=%b exp=1", flash_ack); end
    total++; if (flash_rdata !== 32'hA5A50F0F) begin bad++; $display("FAIL b2b_second_rdata got=%h exp=a5a50f0f", flash_rdata); end
    repeat (50) @(posedge clk);
    #1;
    total++; if (ack_cnt !== 2) begin bad++; $display("FAIL b2b_ack_count got=%0d exp=2", ack_cnt); end
    total++; if (min_gap < 4 || min_gap >= 1000) begin bad++; $display("FAIL b2b_cs_gap got=%0d exp>=4", min_gap); end
  endtask

  task automatic test_reset_mid_data;
    int n;
    ack_cnt = 0;
    flash_address = 32'h0012_3454; flash_write = 1'b0; flash_request = 1'b1;
    n = 0;
    while (!(nrise >= 40 && !spi_cs_n) && n < 2000) begin @(posedge clk); #1; n++; end
    total++; if (nrise !== 40) begin bad++; $display("FAIL midrst_reach_bit40 got=%0d exp=40", nrise); end
    reset_n = 1'b0;
    #1;
    total++; if (spi_cs_n !== 1'b1) begin bad++; $display("FAIL midrst_cs_async got=%b exp=1", spi_cs_n); end
    total++; if (spi_clk !== 1'b0) begin bad++; $display("FAIL midrst_sck got=%b exp=0", spi_clk); end
    flash_request = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++; if (ack_cnt !== 0) begin bad++; $display("FAIL midrst_no_ack got=%0d exp=0", ack_cnt); end
    total++; if (flash_rdata !== 32'h0) begin bad++; $display("FAIL midrst_rdata got=%h exp=0", flash_rdata); end
    flash_request = 1'b1;
    n = 0;
    while (!flash_ack && n < 2000) begin @(posedge clk); #1; n++; end
    flash_request = 1'b0;
    total++; if (n !== RD_LAT) begin bad++; $display("FAIL midrst_next_latency got=%0d exp=%0d", n, RD_LAT); end
    total++; if (flash_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL midrst_next_rdata got=%h exp=deadbeef", flash_rdata); end
    repeat (10) @(posedge clk);
    #1;
    total++; if (ack_cnt !== 1) begin bad++; $display("FAIL midrst_next_ack_count got=%0d exp=1", ack_cnt); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
